// File: rtl/iter_seq_ctrl.sv
// iter_seq_ctrl
//   Sequencing controller for multi-cycle iterative datapaths (shift-add
//   multiplier, restoring divider, CORDIC). It owns the iteration counter
//   and runs IDLE -> LOAD -> ITER (N cycles) -> DONE. Enables decode from
//   the state register only (Moore).
//
// Parameters:
//   CNT_W     width of iters_in / iter_idx; maximum count is 2**CNT_W
//   HOLD_DONE 1: DONE is held while start stays high; 0: DONE lasts one cycle
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     run request, sampled only in IDLE
//   iters_in  iteration count, latched at start (0 means 2**CNT_W)
//   abort     cancel request (used only when ITER_SEQ_CTRL_ABORT_EN is defined)
//   sel       operand mux select (0 initial operands, 1 feedback)
//   load_en   working-register load enable (LOAD)
//   iter_en   working-register iterate enable (ITER)
//   out_en    result-register enable (DONE)
//   busy      high in LOAD and ITER
//   done      high in DONE
//   aborted   one-cycle pulse in the first IDLE cycle after an abort
//   iter_idx  current iteration index
//
// Build option:
//   ITER_SEQ_CTRL_ABORT_EN  when defined, abort in LOAD/ITER returns to IDLE
//                           and skips DONE; otherwise abort is ignored and
//                           aborted is tied low.

module iter_seq_ctrl #(
  parameter int CNT_W     = 6,
  parameter bit HOLD_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] iters_in,
  input  logic             abort,
  output logic             sel,
  output logic             load_en,
  output logic             iter_en,
  output logic             out_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] iter_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W:0]   n_lat;      // one extra bit so that 2**CNT_W is representable
  logic [CNT_W-1:0] idx_q;
  logic             last_iter;
  logic             abort_hit;

  // N-1 always fits in CNT_W bits, so compare on the widened index
  assign last_iter = ({1'b0, idx_q} == (n_lat - (CNT_W+1)'(1)));

`ifdef ITER_SEQ_CTRL_ABORT_EN
  logic aborted_q;

  assign abort_hit = abort && ((state == S_LOAD) || (state == S_ITER));
  assign aborted   = aborted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end
`else
  logic unused_abort;

  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
  assign aborted      = 1'b0;
`endif

  // Next-state logic; abort overrides every other transition, including
  // the move from the final ITER cycle to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ITER;
      S_ITER:  if (last_iter) state_nxt = S_DONE;
      S_DONE:  if (!HOLD_DONE || !start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  // Moore output decode
  always_comb begin
    sel     = 1'b0;
    load_en = 1'b0;
    iter_en = 1'b0;
    out_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_LOAD: begin
        load_en = 1'b1;
        busy    = 1'b1;
      end
      S_ITER: begin
        iter_en = 1'b1;
        sel     = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        out_en = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      n_lat <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nxt;

      if ((state == S_IDLE) && start) begin
        n_lat <= (iters_in == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, iters_in};
      end

      // Index is driven from the next state so it reads 0..N-1 during ITER,
      // holds N-1 through DONE and is zero in IDLE/LOAD.
      case (state_nxt)
        S_ITER:  idx_q <= (state == S_ITER) ? idx_q + 1'b1 : '0;
        S_DONE:  idx_q <= idx_q;
        default: idx_q <= '0;
      endcase
    end
  end

  assign iter_idx = idx_q;

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Testbench for iter_seq_ctrl: two instances (HOLD_DONE=1 as A,
// HOLD_DONE=0 as B). Stimulus pushes the expected output word for the cycle
// following each clock edge into a per-instance queue; a monitor pops and
// compares on the falling edge.

module tb_iter_seq_ctrl;

  localparam int ST_I = 0;
  localparam int ST_L = 1;
  localparam int ST_T = 2;
  localparam int ST_D = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_start, a_abort, b_start, b_abort;
  logic [5:0] a_iters, b_iters;
  logic       a_sel, a_load_en, a_iter_en, a_out_en, a_busy, a_done, a_aborted;
  logic       b_sel, b_load_en, b_iter_en, b_out_en, b_busy, b_done, b_aborted;
  logic [5:0] a_idx, b_idx;

  iter_seq_ctrl #(.CNT_W(6), .HOLD_DONE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .iters_in(a_iters), .abort(a_abort),
    .sel(a_sel), .load_en(a_load_en), .iter_en(a_iter_en), .out_en(a_out_en),
    .busy(a_busy), .done(a_done), .aborted(a_aborted), .iter_idx(a_idx)
  );

  iter_seq_ctrl #(.CNT_W(6), .HOLD_DONE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .iters_in(b_iters), .abort(b_abort),
    .sel(b_sel), .load_en(b_load_en), .iter_en(b_iter_en), .out_en(b_out_en),
    .busy(b_busy), .done(b_done), .aborted(b_aborted), .iter_idx(b_idx)
  );

  // {sel, load_en, iter_en, out_en, busy, done, aborted, iter_idx}
  logic [12:0] a_act, b_act;
  assign a_act = {a_sel, a_load_en, a_iter_en, a_out_en, a_busy, a_done, a_aborted, a_idx};
  assign b_act = {b_sel, b_load_en, b_iter_en, b_out_en, b_busy, b_done, b_aborted, b_idx};

  logic [12:0] qa[$];
  logic [12:0] qb[$];
  int          checks = 0;
  int          errors = 0;
  string       tname  = "init";

  function automatic logic [12:0] ev(input int st, input int idx, input bit ab);
    logic       s, l, t, o, b, d;
    logic [5:0] ix;
    s = 1'b0; l = 1'b0; t = 1'b0; o = 1'b0; b = 1'b0; d = 1'b0;
    ix = idx[5:0];
    case (st)
      ST_L: begin l = 1'b1; b = 1'b1; end
      ST_T: begin s = 1'b1; t = 1'b1; b = 1'b1; end
      ST_D: begin o = 1'b1; d = 1'b1; end
      default: ;
    endcase
    return {s, l, t, o, b, d, ab, ix};
  endfunction

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b (sel,load,iter,out,busy,done,abrt,idx)",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check({tname, "/A"}, a_act, e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check({tname, "/B"}, b_act, e);
    end
  end

  // Drive one instance's inputs, clock once, queue the expected output word.
  task automatic tick(input bit which, input bit st, input int it, input bit ab,
                      input logic [12:0] e);
    if (!which) begin
      a_start = st; a_iters = it[5:0]; a_abort = ab;
    end else begin
      b_start = st; b_iters = it[5:0]; b_abort = ab;
    end
    @(posedge clk);
    #1;
    if (!which) qa.push_back(e);
    else        qb.push_back(e);
    @(negedge clk);
  endtask

  // Start pulse, full run, start low during DONE -> back to IDLE.
  task automatic run_plain(input bit which, input int it, input int n);
    tick(which, 1'b1, it, 1'b0, ev(ST_L, 0, 1'b0));
    for (int k = 0; k < n; k++) tick(which, 1'b0, it, 1'b0, ev(ST_T, k, 1'b0));
    tick(which, 1'b0, it, 1'b0, ev(ST_D, n - 1, 1'b0));
    tick(which, 1'b0, it, 1'b0, ev(ST_I, 0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_iters = '0; a_abort = 1'b0;
    b_start = 1'b0; b_iters = '0; b_abort = 1'b0;
    #12;
    check("reset_state/A", a_act, 13'd0);
    check("reset_state/B", b_act, 13'd0);
    @(negedge clk);
    reset = 1'b0;

    tname = "idle";
    tick(1'b0, 1'b0, 0, 1'b0, ev(ST_I, 0, 1'b0));

    // Asynchronous reset in the middle of ITER
    tname = "reset_mid";
    tick(1'b0, 1'b1, 10, 1'b0, ev(ST_L, 0, 1'b0));
    for (int k = 0; k <= 4; k++) tick(1'b0, 1'b0, 10, 1'b0, ev(ST_T, k, 1'b0));
    #2 reset = 1'b1;
    #1 check("async_reset/A", a_act, 13'd0);
    #1 reset = 1'b0;
    tick(1'b0, 1'b0, 10, 1'b0, ev(ST_I, 0, 1'b0));

    tname = "run10";
    run_plain(1'b0, 10, 10);

    tname = "iters0";
    run_plain(1'b0, 0, 64);

    // HOLD_DONE=1: DONE held while start stays high
    tname = "hold";
    tick(1'b0, 1'b1, 1, 1'b0, ev(ST_L, 0, 1'b0));
    tick(1'b0, 1'b1, 1, 1'b0, ev(ST_T, 0, 1'b0));
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 1, 1'b0, ev(ST_D, 0, 1'b0));
    tick(1'b0, 1'b0, 1, 1'b0, ev(ST_I, 0, 1'b0));

    // HOLD_DONE=0 with start held: period 6; iters change lands next run
    tname = "auto";
    for (int r = 0; r < 2; r++) begin
      tick(1'b1, 1'b1, 3, 1'b0, ev(ST_L, 0, 1'b0));
      for (int k = 0; k < 3; k++)
        tick(1'b1, 1'b1, (r == 1) ? 5 : 3, 1'b0, ev(ST_T, k, 1'b0));
      tick(1'b1, 1'b1, (r == 1) ? 5 : 3, 1'b0, ev(ST_D, 2, 1'b0));
      tick(1'b1, 1'b1, (r == 1) ? 5 : 3, 1'b0, ev(ST_I, 0, 1'b0));
    end
    tick(1'b1, 1'b1, 5, 1'b0, ev(ST_L, 0, 1'b0));
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 5, 1'b0, ev(ST_T, k, 1'b0));
    tick(1'b1, 1'b1, 5, 1'b0, ev(ST_D, 4, 1'b0));
    tick(1'b1, 1'b0, 5, 1'b0, ev(ST_I, 0, 1'b0));
    tick(1'b1, 1'b0, 5, 1'b0, ev(ST_I, 0, 1'b0));

    // Abort at iter_idx=5 of an 8-iteration run
    tname = "abort_mid";
    tick(1'b0, 1'b1, 8, 1'b0, ev(ST_L, 0, 1'b0));
    for (int k = 0; k <= 5; k++) tick(1'b0, 1'b0, 8, 1'b0, ev(ST_T, k, 1'b0));
`ifdef ITER_SEQ_CTRL_ABORT_EN
    tick(1'b0, 1'b0, 8, 1'b1, ev(ST_I, 0, 1'b1));
    tick(1'b0, 1'b0, 8, 1'b0, ev(ST_I, 0, 1'b0));
`else
    tick(1'b0, 1'b0, 8, 1'b1, ev(ST_T, 6, 1'b0));
    tick(1'b0, 1'b0, 8, 1'b0, ev(ST_T, 7, 1'b0));
    tick(1'b0, 1'b0, 8, 1'b0, ev(ST_D, 7, 1'b0));
    tick(1'b0, 1'b0, 8, 1'b0, ev(ST_I, 0, 1'b0));
`endif

    // Abort coinciding with the final ITER cycle
    tname = "abort_last";
    tick(1'b0, 1'b1, 4, 1'b0, ev(ST_L, 0, 1'b0));
    for (int k = 0; k <= 3; k++) tick(1'b0, 1'b0, 4, 1'b0, ev(ST_T, k, 1'b0));
`ifdef ITER_SEQ_CTRL_ABORT_EN
    tick(1'b0, 1'b0, 4, 1'b1, ev(ST_I, 0, 1'b1));
`else
    tick(1'b0, 1'b0, 4, 1'b1, ev(ST_D, 3, 1'b0));
`endif
    tick(1'b0, 1'b0, 4, 1'b0, ev(ST_I, 0, 1'b0));

    // Abort has no effect in IDLE or DONE
    tname = "abort_ignored";
    tick(1'b0, 1'b0, 1, 1'b1, ev(ST_I, 0, 1'b0));
    tick(1'b0, 1'b1, 1, 1'b0, ev(ST_L, 0, 1'b0));
    tick(1'b0, 1'b1, 1, 1'b0, ev(ST_T, 0, 1'b0));
    tick(1'b0, 1'b1, 1, 1'b0, ev(ST_D, 0, 1'b0));
    tick(1'b0, 1'b1, 1, 1'b1, ev(ST_D, 0, 1'b0));
    tick(1'b0, 1'b0, 1, 1'b0, ev(ST_I, 0, 1'b0));

    @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d required=0", qa.size() + qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
